// File: rtl/du_pkg.sv
// ---------------------------------------------------------------------------
// du_pkg: shared types and defaults for the debug-unit TX path.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package du_pkg;

  localparam int UART_W        = 8;
  localparam int DEF_MAX_FRAME = 512;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_START  = 2'd2,
    ST_DRAIN  = 2'd3
  } du_state_t;

endpackage

`default_nettype wire

// File: rtl/du_rr_arbiter.sv
// ---------------------------------------------------------------------------
// du_rr_arbiter: combinational round-robin pick, first request at/after ptr.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module du_rr_arbiter
  import du_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_CH-1:0]  grant
);

  logic found;

  // Scan priority slots ptr, ptr+1, ... (mod N_CH); the first requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!found && req[c] && (((int'(ptr) + i) % N_CH) == c)) begin
          grant[c] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/du_tx_arbiter.sv
// ---------------------------------------------------------------------------
// du_tx_arbiter: frame-level round-robin merge of debug-unit byte streams
// onto the UART TX FIFO, with backpressure and per-frame tx_start.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module du_tx_arbiter
  import du_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int NB_UART_DATA = UART_W,
  parameter int NB_LEN       = 10,
  parameter int MAX_FRAME    = DEF_MAX_FRAME
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic [N_CH-1:0]              i_valid,
  input  logic [N_CH*NB_UART_DATA-1:0] i_data,
  input  logic [N_CH-1:0]              i_last,
  output logic [N_CH-1:0]              o_ready,
  input  logic                         i_fifo_full,
  input  logic                         i_fifo_empty,
  output logic                         o_wr,
  output logic [NB_UART_DATA-1:0]      o_wdata,
  output logic                         o_tx_start,
  output logic [N_CH-1:0]              o_grant,
  output logic                         o_busy,
  output logic [N_CH-1:0]              o_trunc
);

  localparam int                PTR_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [NB_LEN-1:0] C_LEN_LIMIT = NB_LEN'(MAX_FRAME - 1);

  du_state_t               r_state, w_state_nx;
  logic [N_CH-1:0]         r_grant, w_grant_nx, w_arb_grant;
  logic [N_CH-1:0]         r_trunc, w_trunc_nx, w_accept;
  logic [PTR_W-1:0]        r_ptr, w_ptr_nx, w_owner, w_owner_nx;
  logic [NB_LEN-1:0]       r_len, w_len_nx;
  logic                    r_wr, w_wr_nx, r_tx_start, w_tx_start_nx;
  logic [NB_UART_DATA-1:0] r_wdata, w_wdata_nx, w_sel_data;
  logic                    w_xfer, w_last, w_eof;

  du_rr_arbiter #(
    .N_CH  (N_CH),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (i_valid),
    .ptr   (r_ptr),
    .grant (w_arb_grant)
  );

  assign o_ready  = (r_state == ST_STREAM && !i_fifo_full) ? r_grant : '0;
  assign w_accept = i_valid & o_ready;
  assign w_xfer   = |w_accept;
  assign w_last   = |(w_accept & i_last);
  assign w_eof    = w_xfer && (w_last || (r_len == C_LEN_LIMIT));

  always_comb begin
    w_owner    = '0;
    w_sel_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (r_grant[c]) begin
        w_owner    = PTR_W'(c);
        w_sel_data = i_data[c*NB_UART_DATA +: NB_UART_DATA];
      end
    end
  end

  assign w_owner_nx = (w_owner == PTR_W'(N_CH - 1)) ? '0 : w_owner + PTR_W'(1);

  always_comb begin
    w_state_nx    = r_state;
    w_grant_nx    = r_grant;
    w_ptr_nx      = r_ptr;
    w_len_nx      = r_len;
    w_trunc_nx    = r_trunc;
    w_wr_nx       = 1'b0;
    w_wdata_nx    = r_wdata;
    w_tx_start_nx = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|i_valid) begin
          w_grant_nx = w_arb_grant;
          w_len_nx   = '0;
          w_state_nx = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_xfer) begin
          w_wr_nx    = 1'b1;
          w_wdata_nx = w_sel_data;
          w_len_nx   = r_len + NB_LEN'(1);
          if (w_eof) begin
            w_state_nx = ST_START;
            w_ptr_nx   = w_owner_nx;
            // A frame that ends naturally on its MAX_FRAME-th byte was not cut.
            if (!w_last) w_trunc_nx = r_trunc | r_grant;
          end
        end
      end
      ST_START: begin
        w_tx_start_nx = 1'b1;
        w_state_nx    = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_fifo_empty) begin
          w_grant_nx = '0;
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_len      <= '0;
      r_trunc    <= '0;
      r_wr       <= 1'b0;
      r_wdata    <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_grant    <= w_grant_nx;
      r_ptr      <= w_ptr_nx;
      r_len      <= w_len_nx;
      r_trunc    <= w_trunc_nx;
      r_wr       <= w_wr_nx;
      r_wdata    <= w_wdata_nx;
      r_tx_start <= w_tx_start_nx;
    end
  end

  assign o_wr       = r_wr;
  assign o_wdata    = r_wdata;
  assign o_tx_start = r_tx_start;
  assign o_grant    = r_grant;
  assign o_trunc    = r_trunc;
  assign o_busy     = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_du_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_du_tx_arbiter: table-driven frames plus hand sequences, byte scoreboard.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_du_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           i_rst;
  logic [N-1:0]   i_valid;
  logic [N*W-1:0] i_data;
  logic [N-1:0]   i_last;
  logic [N-1:0]   o_ready;
  logic           i_fifo_full;
  logic           i_fifo_empty;
  logic           o_wr;
  logic [W-1:0]   o_wdata;
  logic           o_tx_start;
  logic [N-1:0]   o_grant;
  logic           o_busy;
  logic [N-1:0]   o_trunc;

  du_tx_arbiter #(
    .N_CH         (N),
    .NB_UART_DATA (W),
    .NB_LEN       (10),
    .MAX_FRAME    (4)
  ) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .i_fifo_full  (i_fifo_full),
    .i_fifo_empty (i_fifo_empty),
    .o_wr         (o_wr),
    .o_wdata      (o_wdata),
    .o_tx_start   (o_tx_start),
    .o_grant      (o_grant),
    .o_busy       (o_busy),
    .o_trunc      (o_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    int         n;
    logic [7:0] base;
    int         stall_at;
    int         stall_len;
    logic [3:0] trunc;
    int         starts;
  } vec_t;

  vec_t       tbl [4];
  logic [7:0] exp_q [$];
  int         n_cmp;
  int         n_fail;
  int         n_starts;
  logic       prev_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (o_wr) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_wr: got 0x%0h, want no write at %0t", o_wdata, $time);
        end else begin
          e = exp_q.pop_front();
          check("wdata_order", 32'(o_wdata), 32'(e));
        end
      end
      if (o_tx_start) begin
        n_starts++;
        check("start_after_wr", 32'(prev_wr), 32'd1);
        check("start_not_with_wr", 32'(o_wr), 32'd0);
      end
      prev_wr = o_wr;
    end
  endtask

  task automatic drive_frame(input int ch, input int n, input logic [7:0] base,
                             input int stall_at, input int stall_len);
    logic       pend;
    logic [7:0] pb;
    int         waited;
    pend = 1'b0;
    pb   = '0;
    for (int i = 0; i < n; i++) begin
      i_valid[ch]        = 1'b1;
      i_data[ch*W +: W]  = base + 8'(i);
      i_last[ch]         = (i == n - 1);
      if (i == stall_at) begin
        i_fifo_full = 1'b1;
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          if (pend) begin
            check("wr_latency", 32'(o_wr), 32'd1);
            check("wdata_latency", 32'(o_wdata), 32'(pb));
            pend = 1'b0;
          end
          check("stall_ready", 32'(o_ready), 32'd0);
          if (k > 0) check("stall_wr", 32'(o_wr), 32'd0);
          @(posedge clk);
          #1;
        end
        i_fifo_full = 1'b0;
      end
      @(negedge clk);
      if (pend) begin
        check("wr_latency", 32'(o_wr), 32'd1);
        check("wdata_latency", 32'(o_wdata), 32'(pb));
        pend = 1'b0;
      end
      waited = 0;
      while (!o_ready[ch] && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!o_ready[ch]) begin
        check("ready_timeout", 32'(o_ready[ch]), 32'd1);
        i_valid[ch] = 1'b0;
        i_last[ch]  = 1'b0;
        return;
      end
      check("grant_owner", 32'(o_grant), 32'(1 << ch));
      @(posedge clk);
      #1;
      pend = 1'b1;
      pb   = base + 8'(i);
    end
    i_valid[ch] = 1'b0;
    i_last[ch]  = 1'b0;
    @(negedge clk);
    if (pend) begin
      check("wr_latency", 32'(o_wr), 32'd1);
      check("wdata_latency", 32'(o_wdata), 32'(pb));
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (o_busy && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("idle_reached", 32'(o_busy), 32'd0);
    check("idle_grant", 32'(o_grant), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 i_rst = 1'b1;
    @(posedge clk);
    #1 i_rst = 1'b0;
  endtask

  initial begin
    int s0;
    int w;
    n_cmp        = 0;
    n_fail       = 0;
    n_starts     = 0;
    prev_wr      = 1'b0;
    i_rst        = 1'b1;
    i_valid      = '0;
    i_data       = '0;
    i_last       = '0;
    i_fifo_full  = 1'b0;
    i_fifo_empty = 1'b1;

    tbl[0] = '{ch: 2, n: 3, base: 8'hA1, stall_at: -1, stall_len: 0, trunc: 4'b0000, starts: 1};
    tbl[1] = '{ch: 3, n: 3, base: 8'h30, stall_at:  1, stall_len: 5, trunc: 4'b0000, starts: 1};
    tbl[2] = '{ch: 1, n: 6, base: 8'h10, stall_at: -1, stall_len: 0, trunc: 4'b0010, starts: 2};
    tbl[3] = '{ch: 0, n: 2, base: 8'hC0, stall_at:  0, stall_len: 2, trunc: 4'b0010, starts: 1};

    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_wr", 32'(o_wr), 32'd0);
    check("rst_wdata", 32'(o_wdata), 32'd0);
    check("rst_tx_start", 32'(o_tx_start), 32'd0);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_trunc", 32'(o_trunc), 32'd0);
    i_rst = 1'b0;

    // Single frame, backpressure, truncation, stall at frame start.
    for (int t = 0; t < 4; t++) begin
      s0 = n_starts;
      for (int j = 0; j < tbl[t].n; j++) exp_q.push_back(tbl[t].base + 8'(j));
      drive_frame(tbl[t].ch, tbl[t].n, tbl[t].base, tbl[t].stall_at, tbl[t].stall_len);
      wait_idle();
      check("tbl_starts", 32'(n_starts - s0), 32'(tbl[t].starts));
      check("tbl_trunc", 32'(o_trunc), 32'(tbl[t].trunc));
      check("tbl_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Contention with pointer 0: ch0 first, then ch3.
    do_reset();
    check("reset_clears_trunc", 32'(o_trunc), 32'd0);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    fork
      drive_frame(0, 2, 8'h01, -1, 0);
      drive_frame(3, 2, 8'h31, -1, 0);
    join
    wait_idle();

    // ch0 served alone, so it yields to ch3 on the next contention.
    exp_q.push_back(8'h05);
    drive_frame(0, 1, 8'h05, -1, 0);
    wait_idle();
    exp_q.push_back(8'h33); exp_q.push_back(8'h34);
    exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    fork
      drive_frame(0, 2, 8'h03, -1, 0);
      drive_frame(3, 2, 8'h33, -1, 0);
    join
    wait_idle();
    check("contention_queue_empty", 32'(exp_q.size()), 32'd0);

    // Drain hold: FIFO reports non-empty for 20 cycles while ch0 waits.
    i_fifo_empty = 1'b0;
    exp_q.push_back(8'hE1);
    exp_q.push_back(8'hD0); exp_q.push_back(8'hD1);
    drive_frame(2, 1, 8'hE1, -1, 0);
    w = 0;
    while (!o_tx_start && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("drain_start_seen", 32'(o_tx_start), 32'd1);
    i_valid[0]   = 1'b1;
    i_data[7:0]  = 8'hD0;
    i_last[0]    = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("drain_ready", 32'(o_ready), 32'd0);
      check("drain_wr", 32'(o_wr), 32'd0);
      check("drain_busy", 32'(o_busy), 32'd1);
    end
    i_fifo_empty = 1'b1;
    drive_frame(0, 2, 8'hD0, -1, 0);
    wait_idle();

    // Asynchronous reset in the middle of a ch1 frame.
    i_valid[1]    = 1'b1;
    i_data[15:8]  = 8'h55;
    i_last[1]     = 1'b0;
    w = 0;
    @(negedge clk);
    while (!o_ready[1] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("arst_pre_grant", 32'(o_grant), 32'h2);
    @(posedge clk);
    #1 i_valid[1] = 1'b0;
    #2;
    check("arst_pre_busy", 32'(o_busy), 32'd1);
    check("arst_pre_wr", 32'(o_wr), 32'd1);
    i_rst = 1'b1;
    #1;
    check("arst_grant", 32'(o_grant), 32'd0);
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_wr", 32'(o_wr), 32'd0);
    check("arst_wdata", 32'(o_wdata), 32'd0);
    check("arst_ready", 32'(o_ready), 32'd0);
    check("arst_tx_start", 32'(o_tx_start), 32'd0);
    check("arst_trunc", 32'(o_trunc), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 i_rst = 1'b0;

    // Pointer restarts at 0: ch0 beats ch3.
    exp_q.push_back(8'h71); exp_q.push_back(8'h72);
    exp_q.push_back(8'h81);
    fork
      drive_frame(0, 2, 8'h71, -1, 0);
      drive_frame(3, 1, 8'h81, -1, 0);
    join
    wait_idle();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
